// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte/bit-count widths and the receiver state encoding.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam int unsigned SPI_BIT_CNT_W = 3;

  typedef enum logic [0:0] {
    RX_IDLE,
    RX_SHIFT
  } spi_rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Byte FIFO with first-word fall-through read; a push into a full FIFO succeeds when
// a pop happens on the same edge.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [SPI_BYTE_W-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [SPI_BYTE_W-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [SPI_BYTE_W-1:0] mem_q [Depth];
  logic                  pop, push;

  assign empty_o = (wptr_q == rptr_q);
  // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign pop       = rd_en_i && !empty_o;
  assign push      = wr_en_i && (!full_o || pop);
  assign rd_data_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wptr_q[AddrW-1:0]] <= wr_data_i;
        wptr_q                   <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_byte_rx.sv
// Slave-side SPI byte receiver with valid/ready output. Define SPI_RX_FIFO_EN to replace
// the single holding register with a FIFO_DEPTH-entry byte FIFO.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  sda,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  busy
);

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_param_err
    $error("spi_byte_rx: SYNC_STAGES >= 2 and FIFO_DEPTH in 2..16 required");
  end

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sda_sync_q;

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    logic cs_in, sclk_in, sda_in;
    if (g == 0) begin : g_src
      assign cs_in   = cs;
      assign sclk_in = sclk;
      assign sda_in  = sda;
    end else begin : g_src
      assign cs_in   = cs_sync_q[g-1];
      assign sclk_in = sclk_sync_q[g-1];
      assign sda_in  = sda_sync_q[g-1];
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cs_sync_q[g]   <= 1'b1;
        sclk_sync_q[g] <= 1'b0;
        sda_sync_q[g]  <= 1'b0;
      end else begin
        cs_sync_q[g]   <= cs_in;
        sclk_sync_q[g] <= sclk_in;
        sda_sync_q[g]  <= sda_in;
      end
    end
  end

  logic cs_s, sclk_s;
  logic sclk_d_q, sda_d_q;
  logic rise, shift_en, byte_done;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d_q <= 1'b0;
      sda_d_q  <= 1'b0;
    end else begin
      sclk_d_q <= sclk_s;
      sda_d_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  // sda_d_q is the pre-edge data: the transmitter moves sda on the same edge as sclk.
  assign rise      = sclk_s && !sclk_d_q;
  assign shift_en  = rise && !cs_s;

  logic [SPI_BYTE_W-2:0]    shreg_q, shreg_d;
  logic [SPI_BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
  spi_rx_state_t            state_q, state_d;
  logic                     wr_q, wr_d;
  logic [SPI_BYTE_W-1:0]    wr_data_q, wr_data_d;

  assign byte_done = shift_en && (bitcnt_q == SPI_BIT_CNT_W'(SPI_BYTE_W - 1));

  always_comb begin
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    state_d   = state_q;
    wr_d      = byte_done;
    wr_data_d = wr_data_q;
    if (cs_s) begin
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (rise) begin
      shreg_d  = {shreg_q[SPI_BYTE_W-3:0], sda_d_q};
      bitcnt_d = bitcnt_q + SPI_BIT_CNT_W'(1);
    end
    if (byte_done) begin
      wr_data_d = {shreg_q, sda_d_q};
    end
    case (state_q)
      RX_IDLE:  if (shift_en) state_d = RX_SHIFT;
      RX_SHIFT: if (cs_s || byte_done) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  assign busy = (state_q == RX_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      state_q   <= RX_IDLE;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      state_q   <= state_d;
      wr_q      <= wr_d;
      wr_data_q <= wr_data_d;
    end
  end

  logic overrun_q, overrun_d;
  logic pop;

  assign pop     = rx_valid && rx_ready;
  assign overrun = overrun_q;

`ifdef SPI_RX_FIFO_EN
  logic                  wr2_q;
  logic [SPI_BYTE_W-1:0] wr2_data_q;
  logic                  fifo_empty, fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr2_q      <= 1'b0;
      wr2_data_q <= '0;
    end else begin
      wr2_q      <= wr_q;
      wr2_data_q <= wr_data_q;
    end
  end

  spi_rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (wr2_q),
    .wr_data_i (wr2_data_q),
    .rd_en_i   (rx_ready),
    .rd_data_o (rx_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign rx_valid  = !fifo_empty;
  assign overrun_d = wr2_q && fifo_full && !pop;
`else
  logic                  full_q, full_d;
  logic [SPI_BYTE_W-1:0] hold_q, hold_d;

  always_comb begin
    full_d    = full_q;
    hold_d    = hold_q;
    overrun_d = 1'b0;
    if (wr_q && (!full_q || pop)) begin
      full_d = 1'b1;
      hold_d = wr_data_q;
    end else if (wr_q) begin
      overrun_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end

  assign rx_valid = full_q;
  assign rx_data  = hold_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: drives SPI frames like the transmitter and checks the
// delivered bytes, latency, busy, overrun and reset behaviour against hand-computed values.
module tb_spi_byte_rx;

  localparam int unsigned SyncStages = 2;
`ifdef SPI_RX_FIFO_EN
  localparam int unsigned Lat   = SyncStages + 2;
  localparam int unsigned NFill = 4;
`else
  localparam int unsigned Lat   = SyncStages + 1;
  localparam int unsigned NFill = 1;
`endif
  localparam int unsigned Half = 10;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       cs       = 1'b1;
  logic       sclk     = 1'b0;
  logic       sda      = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       busy;

  spi_byte_rx #(
    .SYNC_STAGES (SyncStages),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .sclk     (sclk),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and overrun cycles are observed at the falling edge, half a cycle before
  // the rising edge that acts on them.
  logic [7:0] got_q[$];
  int         ovr_cnt    = 0;
  int         valid_cyc  = 0;
  logic       valid_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (overrun) ovr_cnt++;
    if (rx_valid && !valid_prev) valid_cyc = cyc;
    valid_prev = rx_valid;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int rise8_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // MSB first; sda flips on the rising edge so only the pre-edge value is the real bit.
  // With arm set, rx_ready is raised so it lands on the edge that stores this byte.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit arm);
    for (int i = 0; i < nbits; i++) begin
      sda = b[7-i];
      tick(Half);
      sclk = 1'b1;
      sda  = ~b[7-i];
      if (i == 7) rise8_cyc = cyc;
      if (arm && i == 7) begin
        tick(Lat);
        rx_ready = 1'b1;
        tick(Half - Lat);
      end else begin
        tick(Half);
      end
      sclk = 1'b0;
    end
  endtask

  int         base;
  int         ob;
  logic [7:0] v;
  logic [7:0] b2b[3] = '{8'h00, 8'hFF, 8'h3C};

  initial begin
    tick(3);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(2);
    cs = 1'b0;
    tick(4);
    rx_ready = 1'b1;

    base = got_q.size();
    ob   = ovr_cnt;
    send_bits(8'hA5, 8, 1'b0);
    tick(4);
    check("single_count", got_q.size() - base, 1);
    check("single_data", 32'(got_q[base]), 32'hA5);
    check("single_latency", valid_cyc - rise8_cyc, Lat + 1);
    check("single_overrun", ovr_cnt - ob, 0);

    base = got_q.size();
    for (int k = 0; k < 3; k++) begin
      send_bits(b2b[k], 8, 1'b0);
      check("b2b_busy_low", 32'(busy), 32'h0);
    end
    tick(4);
    check("b2b_count", got_q.size() - base, 3);
    for (int k = 0; k < 3; k++) check("b2b_data", 32'(got_q[base+k]), 32'(b2b[k]));

    base = got_q.size();
    ob   = ovr_cnt;
    send_bits(8'h81, 5, 1'b0);
    check("abort_busy_mid", 32'(busy), 32'h1);
    cs = 1'b1;
    tick(6);
    check("abort_busy_cs_high", 32'(busy), 32'h0);
    cs = 1'b0;
    tick(4);
    send_bits(8'h7E, 8, 1'b0);
    tick(4);
    check("abort_count", got_q.size() - base, 1);
    check("abort_data", 32'(got_q[base]), 32'h7E);
    check("abort_overrun", ovr_cnt - ob, 0);

    rx_ready = 1'b0;
    base = got_q.size();
    ob   = ovr_cnt;
    for (int k = 0; k < NFill + 1; k++) begin
      v = 8'(17 * (k + 1));
      send_bits(v, 8, 1'b0);
    end
    tick(4);
    check("ovr_pulse_count", ovr_cnt - ob, 1);
    check("ovr_valid_held", 32'(rx_valid), 32'h1);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    tick(NFill + 3);
    check("ovr_drain_count", got_q.size() - base, NFill);
    check("ovr_first", 32'(got_q[base]), 32'h11);
    check("ovr_last", 32'(got_q[base+NFill-1]), 32'(17 * NFill));

    rx_ready = 1'b0;
    base = got_q.size();
    send_bits(8'h5A, 8, 1'b0);
    tick(4);
    check("rst_pre_valid", 32'(rx_valid), 32'h1);
    send_bits(8'hE0, 3, 1'b0);
    reset = 1'b0;
    tick(1);
    check("rst_mid_rx_data", 32'(rx_data), 32'h0);
    check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_mid_overrun", 32'(overrun), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    rx_ready = 1'b1;
    reset    = 1'b1;
    tick(4);
    send_bits(8'hC3, 8, 1'b0);
    tick(4);
    check("rst_after_count", got_q.size() - base, 1);
    check("rst_after_data", 32'(got_q[base]), 32'hC3);

    rx_ready = 1'b0;
    base = got_q.size();
    ob   = ovr_cnt;
    for (int k = 0; k < NFill; k++) begin
      v = 8'(8'h40 + k);
      send_bits(v, 8, 1'b0);
    end
    send_bits(8'h99, 8, 1'b1);
    tick(NFill + 4);
    check("fullrd_overrun", ovr_cnt - ob, 0);
    check("fullrd_count", got_q.size() - base, NFill + 1);
    for (int k = 0; k < NFill; k++) check("fullrd_order", 32'(got_q[base+k]), 32'(8'h40 + k));
    check("fullrd_last", 32'(got_q[base+NFill]), 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
